// File: rtl/insn_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues credit-limited reads, buffers returned words with their PC for decode.
// Latency: request cycle N -> out_valid in cycle N+2. Backpressure: issue stalls when occupancy+inflight reaches FIFO_DEPTH.
module insn_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [INSN_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSN_WIDTH-1:0] out_insn,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_tag;
    logic                  r_inflight;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [INSN_WIDTH-1:0] r_fifo_insn [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];

    logic                  w_flush;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_redir_pc;

    // Credit uses registered occupancy, so a same-cycle pop never frees a slot early.
    assign w_credit   = (int'(r_count) + int'(r_inflight)) < FIFO_DEPTH;
    assign w_flush    = redirect_valid && (r_state != S_BOOT);
    assign w_issue    = (r_state == S_RUN) && !redirect_valid && w_credit;
    assign w_push     = r_inflight && !w_flush;
    assign w_pop      = (r_count != '0) && out_ready;
    assign w_redir_pc = redirect_pc & ~ADDR_WIDTH'(3);

    assign mem_req    = w_issue;
    assign mem_addr   = r_pc;
    assign out_valid  = (r_count != '0);
    assign out_insn   = r_fifo_insn[r_rd_ptr];
    assign out_pc     = r_fifo_pc[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = redirect_valid ? S_FLUSH : S_RUN;
            S_FLUSH: w_state_nxt = redirect_valid ? S_FLUSH : S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_tag      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= w_redir_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_insn[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo_insn[r_wr_ptr] <= mem_rdata;
                r_fifo_pc[r_wr_ptr]   <= r_tag;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl: queue-level reference model checked every cycle, directed scenarios plus random traffic.
module tb_insn_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;

    insn_fetch_ctrl #(
        .ADDR_WIDTH (32),
        .INSN_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word[i] = i, one-cycle registered read.
    logic [31:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = i;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= mem[mem_addr[8:2]];
    end

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0=boot 1=run 2=flush; buffered words as queues.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_q_pc[$];
    logic [31:0] m_q_insn[$];
    bit          m_infl;
    logic [31:0] m_tag;

    logic        obs_v;
    logic        obs_req;
    logic [31:0] obs_pc;
    logic [31:0] obs_insn;
    logic [31:0] acc_pc[$];
    logic [31:0] acc_insn[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h0;
        m_q_pc.delete();
        m_q_insn.delete();
        m_infl  = 0;
        m_tag   = '0;
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit m_v;
        bit m_req;
        bit pop;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        m_v   = (m_q_pc.size() != 0);
        m_req = (m_phase == 1) && !rv && ((m_q_pc.size() + int'(m_infl)) < 2);
        obs_v = out_valid; obs_req = mem_req; obs_pc = out_pc; obs_insn = out_insn;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_v});
        check("mem_req", {31'b0, mem_req}, {31'b0, m_req});
        check("mem_addr", mem_addr, m_pc);
        if (m_v) begin
            check("out_pc", out_pc, m_q_pc[0]);
            check("out_insn", out_insn, m_q_insn[0]);
        end
        if (out_valid && rdy) begin
            acc_pc.push_back(out_pc);
            acc_insn.push_back(out_insn);
        end
        @(posedge clk);
        pop = m_v && rdy;
        if (rv && m_phase != 0) begin
            m_q_pc.delete();
            m_q_insn.delete();
            m_infl  = 0;
            m_pc    = {rpc[31:2], 2'b00};
            m_phase = 2;
        end else begin
            if (pop) begin
                void'(m_q_pc.pop_front());
                void'(m_q_insn.pop_front());
            end
            if (m_infl) begin
                m_q_pc.push_back(m_tag);
                m_q_insn.push_back({25'b0, m_tag[8:2]});
            end
            m_infl = m_req;
            if (m_req) begin
                m_tag = m_pc;
                m_pc  = m_pc + 32'd4;
            end
            if (rv) m_pc = {rpc[31:2], 2'b00};
            m_phase = 1;
        end
    endtask

    task automatic wait_valid(input logic rdy);
        bit found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            step(1'b0, 32'h0, rdy);
            found = obs_v;
        end
        check("wait_valid", {31'b0, found}, 32'd1);
    endtask

    initial begin
        bit found;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        model_reset();
        #12;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_out_insn", out_insn, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // First valid appears after the third edge following release.
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("t1_no_valid_yet", {31'b0, obs_v}, 32'd0);
        step(1'b0, 32'h0, 1'b0);
        check("t1_first_valid", {31'b0, obs_v}, 32'd1);
        check("t1_first_pc", obs_pc, 32'h0);
        check("t1_first_insn", obs_insn, 32'h0);

        // Stall: buffer fills to depth, requests stop, head held.
        for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b0);
        check("t2_held_valid", {31'b0, obs_v}, 32'd1);
        check("t2_held_pc", obs_pc, 32'h0);
        check("t2_no_req", {31'b0, obs_req}, 32'd0);
        check("t2_model_full", m_q_pc.size(), 32'd2);

        acc_pc.delete(); acc_insn.delete();
        for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 1'b1);
        check("t1_stream_len", {31'b0, acc_pc.size() >= 8}, 32'd1);
        for (int i = 0; i < 8 && i < acc_pc.size(); i++) begin
            check("t1_stream_pc", acc_pc[i], i * 4);
            check("t1_stream_insn", acc_insn[i], i);
        end

        // Redirect to unaligned 0x43 lands on 0x40 / word 16.
        step(1'b1, 32'h43, 1'b1);
        wait_valid(1'b1);
        check("t3_pc", obs_pc, 32'h40);
        check("t3_insn", obs_insn, 32'd16);

        // Redirect with a handshake and an in-flight read, then back-to-back redirects.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_q_pc.size() != 0 && m_infl) found = 1;
            else step(1'b0, 32'h0, 1'b1);
        end
        check("t4_setup", {31'b0, found}, 32'd1);
        step(1'b1, 32'h10, 1'b1);
        step(1'b1, 32'h20, 1'b1);
        wait_valid(1'b1);
        check("t4_pc", obs_pc, 32'h20);
        check("t4_insn", obs_insn, 32'd8);

        // Word index wraps at 128 words.
        step(1'b1, 32'h1FC, 1'b1);
        wait_valid(1'b1);
        check("t5_pc0", obs_pc, 32'h1FC);
        check("t5_insn0", obs_insn, 32'd127);
        wait_valid(1'b1);
        check("t5_pc1", obs_pc, 32'h200);
        check("t5_insn1", obs_insn, 32'd0);

        // Asynchronous reset with the buffer full.
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
        check("t6_model_full", m_q_pc.size(), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_mem_req", {31'b0, mem_req}, 32'd0);
        check("t6_mem_addr", mem_addr, 32'h0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_valid(1'b1);
        check("t6_restart_pc", obs_pc, 32'h0);
        check("t6_restart_insn", obs_insn, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
